// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the bit-serial word streamer.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/ser_skid_buf.sv
// One-entry holding buffer in front of the shift register; when empty, the
// incoming word is passed straight through so a same-edge load needs no park.
module ser_skid_buf import ser_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             take,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;

   assign in_ready  = !full_q;
   assign out_valid = full_q | in_valid;
   assign out_data  = full_q ? data_q : in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (full_q) begin
         if (take) full_q <= 1'b0;
      end else if (in_valid && !take) begin
         full_q <= 1'b1;
         data_q <= in_data;
      end
   end

endmodule

// File: rtl/serial_word_streamer.sv
// Parallel-to-serial word streamer, MSB first, with valid/ready on both sides.
// Build option SER_SKID_EN adds a one-entry buffer for zero-bubble streaming.
//
// state | meaning
// IDLE  | no word in flight, waiting for an input transfer
// SHIFT | presenting shift_q MSB; cnt_q is the index of the bit on bit_out
module serial_word_streamer import ser_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             bit_last,
   input  logic             bit_ready
);

   localparam int                 CNT_W   = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
      $error("serial_word_streamer: WIDTH out of range");
   end

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             src_valid;
   logic [WIDTH-1:0] src_data;
   logic             out_xfer, last_xfer, take;

   assign bit_valid = (state_q == SHIFT);
   assign bit_out   = shift_q[WIDTH-1];
   assign bit_last  = bit_valid && (cnt_q == '0);
   assign out_xfer  = bit_valid && bit_ready;
   assign last_xfer = out_xfer && (cnt_q == '0);
   // A new word may enter the shift register when idle or as the last bit leaves.
   assign take      = ((state_q == IDLE) || last_xfer) && src_valid;

`ifdef SER_SKID_EN
   ser_skid_buf #(.WIDTH(WIDTH)) u_skid_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .take      (take),
      .out_valid (src_valid),
      .out_data  (src_data)
   );
`else
   assign in_ready  = (state_q == IDLE);
   assign src_valid = in_valid && in_ready;
   assign src_data  = in_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               shift_d = src_data;
               cnt_d   = CNT_MAX;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (take) begin
               shift_d = src_data;
               cnt_d   = CNT_MAX;
            end else if (out_xfer) begin
               // Shifting past the last bit leaves shift_q all-zero in IDLE.
               shift_d = {shift_q[WIDTH-2:0], 1'b0};
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
